// File: rtl/pattern_sender_pkg.sv
// Shared definitions for the pattern_sender slice: pattern type encodings,
// left-aligned frame images, frame lengths and the controller state encoding.
package pattern_sender_pkg;

  localparam logic PAT_A = 1'b0;  // "0101" + guard 00
  localparam logic PAT_B = 1'b1;  // "101"  + guard 11

  localparam int unsigned FRAME_W = 6;  // widest frame, shifter width

  localparam logic [5:0] FRAME_A = 6'b010100;
  localparam logic [4:0] FRAME_B = 5'b10111;

  localparam logic [2:0] LEN_A = 3'd6;
  localparam logic [2:0] LEN_B = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pattern_sender_if.sv
// Command/stream bundle for pattern_sender.
//   start, ptype, count : command side (driven by the master)
//   ready, busy, x, done, sent : status and serial stream (driven by the slave)
// ptype carries the pattern select (0 = A, 1 = B).
interface pattern_sender_if #(
  parameter int unsigned FRAMES_W = 4
);
  logic                start;
  logic                ptype;
  logic [FRAMES_W-1:0] count;
  logic                ready;
  logic                busy;
  logic                x;
  logic                done;
  logic [FRAMES_W-1:0] sent;

  modport master (
    output start, ptype, count,
    input  ready, busy, x, done, sent
  );

  modport slave (
    input  start, ptype, count,
    output ready, busy, x, done, sent
  );
endinterface

// File: rtl/pattern_sender_frame_shifter.sv
// frame_shifter: parallel-loads one frame image, shifts it out MSB-first and
// flags the last bit of the frame.
//   clk, rst   : clock, synchronous active-high reset
//   load       : load frame selected by ptype, bit position back to 0
//   shift      : advance one bit
//   clear      : drop to idle (output 0)
//   ptype      : frame select for load
//   bit_out    : current serial bit (register output)
//   last       : current bit is the final guard bit of the frame
module frame_shifter
  import pattern_sender_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic shift,
  input  logic clear,
  input  logic ptype,
  output logic bit_out,
  output logic last
);

  logic [FRAME_W-1:0] sr;
  logic [2:0]         pos;
  logic [2:0]         len_m1;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sr     <= '0;
      pos    <= '0;
      len_m1 <= LEN_A - 3'd1;
    end else if (load) begin
      // Type B is left-aligned so both frames leave from the same MSB.
      sr     <= (ptype == PAT_B) ? {FRAME_B, 1'b0} : FRAME_A;
      pos    <= '0;
      len_m1 <= (ptype == PAT_B) ? (LEN_B - 3'd1) : (LEN_A - 3'd1);
    end else if (shift) begin
      sr  <= {sr[FRAME_W-2:0], 1'b0};
      pos <= pos + 3'd1;
    end
  end

  assign bit_out = sr[FRAME_W-1];
  assign last    = (pos == len_m1);

endmodule

// File: rtl/pattern_sender.sv
// pattern_sender: accepts a (type, count) command and shifts out count framed
// patterns on bus.x, one bit per clock, with no gap between frames.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of pattern_sender_if (start/ptype/count in;
//              ready/busy/x/done/sent out, all registered)
module pattern_sender
  import pattern_sender_pkg::*;
#(
  parameter int unsigned FRAMES_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  pattern_sender_if.slave   bus
);

  state_t state, state_nxt;

  logic                type_l;
  logic [FRAMES_W-1:0] count_l;
  logic [FRAMES_W-1:0] sent_q;
  logic [FRAMES_W-1:0] sent_plus1;
  logic                ready_q, busy_q, done_q;

  logic accept, load, shift, clear, inc;
  logic load_type;
  logic sh_bit, sh_last;

  assign sent_plus1 = sent_q + FRAMES_W'(1);
  // On accept the shifter must see the incoming type, not the stale latch.
  assign load_type  = (state == ST_IDLE) ? bus.ptype : type_l;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    clear     = 1'b0;
    inc       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (bus.count != '0) begin
            state_nxt = ST_SEND;
            load      = 1'b1;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_SEND: begin
        if (sh_last) begin
          inc = 1'b1;
          if (sent_plus1 == count_l) begin
            state_nxt = ST_DONE;
            clear     = 1'b1;
          end else begin
            load = 1'b1;
          end
        end else begin
          shift = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      type_l  <= PAT_A;
      count_l <= '0;
      sent_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        type_l  <= bus.ptype;
        count_l <= bus.count;
        sent_q  <= '0;
      end else if (inc) begin
        sent_q <= sent_plus1;
      end
      // Status flags are registered from the next state so they line up
      // with the state they describe.
      ready_q <= (state_nxt == ST_IDLE);
      busy_q  <= (state_nxt == ST_SEND);
      done_q  <= (state_nxt == ST_DONE);
    end
  end

  frame_shifter u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (shift),
    .clear   (clear),
    .ptype   (load_type),
    .bit_out (sh_bit),
    .last    (sh_last)
  );

  assign bus.x     = sh_bit;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sent  = sent_q;

endmodule

// File: tb/tb_pattern_sender.sv
// Directed self-checking bench for pattern_sender. Inputs are driven 1 time
// unit after the rising edge; outputs are checked at that same point. A small
// type-A-only "0101" recognizer samples x on the falling edge.
module tb_pattern_sender;

  localparam int unsigned FW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pattern_sender_if #(.FRAMES_W(FW)) bus ();

  pattern_sender #(.FRAMES_W(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Recognizer model: counts overlapping "0101" occurrences in x.
  logic [3:0]  rec_hist = '0;
  int unsigned rec_cnt  = 0;
  always @(negedge clk) begin
    if ({rec_hist[2:0], bus.x} == 4'b0101) rec_cnt++;
    rec_hist = {rec_hist[2:0], bus.x};
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [FW-1:0] exp_sent);
    check_eq({tag, " x"},     32'(bus.x),     32'd0);
    check_eq({tag, " ready"}, 32'(bus.ready), 32'd1);
    check_eq({tag, " busy"},  32'(bus.busy),  32'd0);
    check_eq({tag, " done"},  32'(bus.done),  32'd0);
    check_eq({tag, " sent"},  32'(bus.sent),  32'(exp_sent));
  endtask

  // Issue a command now (caller is in a ready cycle) and check the whole
  // stream, the done pulse and the return to ready. fbits is the expected
  // frame image, left-aligned, flen its length.
  task automatic run_cmd(input string tag, input logic t, input logic [FW-1:0] c,
                         input logic [5:0] fbits, input int unsigned flen,
                         input bit chk_rec, input int unsigned exp_rec);
    int unsigned base;
    int unsigned total;
    base  = rec_cnt;
    total = int'(c) * flen;
    bus.start = 1'b1;
    bus.ptype = t;
    bus.count = c;
    step();
    bus.start = 1'b0;
    for (int unsigned i = 0; i < total; i++) begin
      check_eq($sformatf("%s x[%0d]", tag, i), 32'(bus.x),
               32'(fbits[5 - (i % flen)]));
      check_eq($sformatf("%s busy[%0d]", tag, i), 32'(bus.busy), 32'd1);
      check_eq($sformatf("%s ready[%0d]", tag, i), 32'(bus.ready), 32'd0);
      check_eq($sformatf("%s done[%0d]", tag, i), 32'(bus.done), 32'd0);
      check_eq($sformatf("%s sent[%0d]", tag, i), 32'(bus.sent), i / flen);
      step();
    end
    check_eq({tag, " done pulse"}, 32'(bus.done),  32'd1);
    check_eq({tag, " done x"},     32'(bus.x),     32'd0);
    check_eq({tag, " done busy"},  32'(bus.busy),  32'd0);
    check_eq({tag, " done ready"}, 32'(bus.ready), 32'd0);
    check_eq({tag, " done sent"},  32'(bus.sent),  32'(c));
    if (chk_rec)
      check_eq({tag, " recognizer"}, rec_cnt - base, exp_rec);
    step();
    check_idle({tag, " after"}, c);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.ptype = 1'b0;
    bus.count = '0;

    // Reset and idle
    step();
    step();
    rst = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      check_idle("reset idle", '0);
      step();
    end

    // Type A, two frames: 010100 010100, recognizer +2
    run_cmd("A2", 1'b0, 4'd2, 6'b010100, 6, 1'b1, 2);

    // Type B, three frames: 10111 x3
    run_cmd("B3", 1'b1, 4'd3, 6'b101110, 5, 1'b0, 0);

    // count = 0: done right after accept, busy never set
    run_cmd("B0", 1'b1, 4'd0, 6'b101110, 5, 1'b1, 0);

    // Type A count 4, ignored start mid-command, then reset in frame 2
    bus.start = 1'b1;
    bus.ptype = 1'b0;
    bus.count = 4'd4;
    step();
    bus.start = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i == 2) begin
        bus.start = 1'b1;
        bus.ptype = 1'b1;
        bus.count = 4'd7;
      end
      if (i == 3) bus.start = 1'b0;
      check_eq($sformatf("abort x[%0d]", i), 32'(bus.x),
               32'(((i % 6) == 1) || ((i % 6) == 3)));
      check_eq($sformatf("abort busy[%0d]", i), 32'(bus.busy), 32'd1);
      check_eq($sformatf("abort sent[%0d]", i), 32'(bus.sent), i / 6);
      if (i != 7) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("abort reset", '0);
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check_idle("abort after", '0);
    end

    // Type A, 15 frames: sent reaches 15 without wrapping, recognizer +15,
    // then a back-to-back type B command on the first ready cycle.
    run_cmd("A15", 1'b0, 4'd15, 6'b010100, 6, 1'b1, 15);
    run_cmd("B1 b2b", 1'b1, 4'd1, 6'b101110, 5, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
